// File: rtl/regfile_onehot_wr.sv
// -----------------------------------------------------------------------------
// regfile_onehot_wr
//
// 32-entry general-purpose register file for the simpleCPU datapath. It sits
// directly behind the 5-to-32 write-address decoder, so the write port is
// selected by the decoder's one-hot Y vector instead of an encoded address.
// Two read ports take encoded 5-bit addresses and return registered data one
// cycle later. A sticky flag records any write strobe that arrives with a
// malformed (multi-hot) select.
//
// Parameters:
//   DW       data width of each register and of wdata / rdata_*
//   ZERO_R0  1: register 0 is hard-wired to zero and ignores writes
//            0: register 0 is an ordinary register
//
// Ports:
//   clk      in   1     system clock, all state changes on the rising edge
//   rst      in   1     synchronous active-high reset
//   we       in   1     global write strobe
//   wsel     in   32    one-hot write select (bit n selects register n)
//   wdata    in   DW    write data
//   raddr_a  in   5     read address, port A
//   raddr_b  in   5     read address, port B
//   rdata_a  out  DW    registered read data, port A
//   rdata_b  out  DW    registered read data, port B
//   sel_err  out  1     sticky: a write was strobed with >1 wsel bit set
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read of a register being written in the
//                      same cycle returns the new data (write-through). When
//                      undefined, such a read returns the pre-write contents.
// -----------------------------------------------------------------------------
module regfile_onehot_wr #(
  parameter int unsigned DW      = 32,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [31:0]   wsel,
  input  logic [DW-1:0] wdata,
  input  logic [4:0]    raddr_a,
  input  logic [4:0]    raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          sel_err
);

  localparam int unsigned NREGS = 32;

  // ---------------------------------------------------------------------------
  // Storage and output registers
  // ---------------------------------------------------------------------------
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;
  logic          sel_err_q, sel_err_d;

  // ---------------------------------------------------------------------------
  // Write-select qualification
  //
  // x & (x - 1) clears the lowest set bit, so it is non-zero exactly when two
  // or more bits are set. An all-zero select is the decoder-disabled case and
  // is neither a write nor an error.
  // ---------------------------------------------------------------------------
  logic        wsel_any;
  logic        wsel_multi;
  logic        wsel_onehot;
  logic [31:0] wsel_low_clr;
  logic [31:0] wr_en;

  assign wsel_low_clr = wsel & (wsel - 32'd1);
  assign wsel_any     = |wsel;
  assign wsel_multi   = |wsel_low_clr;
  assign wsel_onehot  = wsel_any & ~wsel_multi;

  // Per-register write enable. Because a qualified select is one-hot, the
  // select vector itself is the enable vector; register 0 is masked off when
  // it is hard-wired to zero so it can neither be written nor bypassed.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_en = '0;
    if (we && wsel_onehot) begin
      wr_en = wsel;
      if (ZERO_R0 != 0) begin
        wr_en[0] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-port next-state
  //
  // The zero-register override is applied last so it wins over both the array
  // contents and the bypass path.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_a_d = regs_q[raddr_a];
`ifdef REGFILE_BYPASS_EN
    if (wr_en[raddr_a]) begin
      rdata_a_d = wdata;
    end
`endif
    if ((ZERO_R0 != 0) && (raddr_a == 5'd0)) begin
      rdata_a_d = '0;
    end
  end

  always_comb begin
    rdata_b_d = regs_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_en[raddr_b]) begin
      rdata_b_d = wdata;
    end
`endif
    if ((ZERO_R0 != 0) && (raddr_b == 5'd0)) begin
      rdata_b_d = '0;
    end
  end

  // Sticky error: only a strobed multi-hot select counts; with we=0 the select
  // is don't-care. Cleared solely by reset.
  assign sel_err_d = sel_err_q | (we & wsel_multi);

  // ---------------------------------------------------------------------------
  // Register array
  //
  // NOTE: the array is reset explicitly because software relies on every
  // register reading zero after reset; a storage array without that
  // requirement would normally be left unreset so it can map to RAM.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en[i]) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  // Output registers. A read issued during reset returns zero on the next
  // cycle, never the pre-reset contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign sel_err = sel_err_q;

endmodule

// File: doc/regfile_onehot_wr.md
Name: regfile_onehot_wr

Overview:
- 32-entry general-purpose register file for the simpleCPU datapath, directly downstream of the 5-to-32 write-address decoder.
- The write port takes the decoder's 32-bit one-hot output as its write select. There is no encoded write address.
- Two read ports take encoded 5-bit addresses and return registered read data.
- A sticky error flag reports malformed (multi-hot) write selects.

Parameters:
- DW, 32, data width of each register and of wdata/rdata.
- ZERO_R0, 1, when 1 register 0 always reads 0 and ignores writes; when 0 register 0 is an ordinary register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- we  input  1  global write strobe.
- wsel  input  32  one-hot write select, bit n selects register n; driven by the 5-to-32 decoder Y output.
- wdata  input  DW  write data.
- raddr_a  input  5  read address, port A.
- raddr_b  input  5  read address, port B.
- rdata_a  output  DW  registered read data, port A.
- rdata_b  output  DW  registered read data, port B.
- sel_err  output  1  sticky flag: a write was attempted with more than one wsel bit set.

Behaviour:
- Reset (rst=1 at a clock edge):
  - all 32 registers clear to 0;
  - rdata_a, rdata_b and sel_err clear to 0;
  - any write presented in the same cycle is discarded;
  - reset dominates every other event.
- Write:
  - Write qualifier is we=1 and wsel having exactly one bit set.
  - On a qualified write, register n (n = index of the set bit) takes wdata at the clock edge.
  - When ZERO_R0=1 and n=0, the write is silently ignored and no error is raised.
- wsel all-zero with we=1: no write, no error. This is the decoder-disabled case, En=0.
- wsel with two or more bits set and we=1:
  - no register is modified;
  - sel_err is set to 1 at that edge and stays 1 until rst.
- we=0: wsel is ignored entirely, including multi-hot values; no error is raised.
- Read latency is 1 cycle:
  - rdata_a at edge k+1 reflects the register addressed by raddr_a at edge k; port B is identical.
  - With ZERO_R0=1, address 0 always returns 0.
  - Both ports may address the same register; they return identical data.
- Read-during-write to the same register in the same cycle: the result depends on the optional feature below.
- Outputs hold their value between edges; there are no combinational paths from inputs to outputs.
- Reset mid-operation: a read issued in the reset cycle returns 0 on the following cycle, not the pre-reset contents.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through bypass):
  - If a qualified write targets register n and raddr_x = n in the same cycle, rdata_x at the next edge equals wdata.
  - Bypass never applies to register 0 when ZERO_R0=1.
  - Bypass never applies to rejected multi-hot writes.
- Not defined: rdata_x returns the register's pre-write contents; the new value is visible on the next read.

Test Plan:
- Reset then read: rst=1 for 2 cycles; raddr_a=5, raddr_b=31 -> rdata_a=0, rdata_b=0, sel_err=0.
- Walk all registers:
  - For n=1..31: we=1, wsel=1<<n, wdata=32'hA5A5_0000+n.
  - Then read every address on both ports -> rdata = 32'hA5A5_0000+n one cycle after each address.
  - Address 0 reads 0.
- Register 0 protection: we=1, wsel=32'h0000_0001, wdata=32'hFFFF_FFFF; read raddr_a=0 -> rdata_a=0, sel_err=0.
- Multi-hot rejection:
  - Preload r3=32'h1111_1111 and r7=32'h2222_2222.
  - we=1, wsel=32'h0000_0088, wdata=32'hDEAD_BEEF -> r3 and r7 unchanged; sel_err=1 next cycle.
  - sel_err stays 1 across later valid writes; it clears only after rst=1.
  - Same wsel with we=0 -> sel_err stays 0.
- Same-cycle read/write: r9=32'h0000_0009; write wsel=1<<9, wdata=32'h0000_0099 with raddr_a=9 in the same cycle:
  - with REGFILE_BYPASS_EN, rdata_a=32'h0000_0099;
  - without it, rdata_a=32'h0000_0009, then 32'h0000_0099 on the next read.
- Decoder disabled and reset collision:
  - we=1, wsel=0, wdata=32'h1234_5678 -> no register changes, sel_err=0.
  - rst=1 together with we=1, wsel=1<<4 -> r4 reads 0 afterwards.
